ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
// - Execute stage of the 5-stage MIPS pipeline, between the ID/EX and EX/MEM registers.
// - Forwards operands from MEM/WB, runs the ALU and issues the data-memory bridge access.
// - Drives CP0 writes and hazard info, and owns the EX/MEM pipeline register.
// PARAMETERS
// - WB_W  4  width of wb_ctrl {reg_write,mem_to_reg,is_dm_byte,is_dm_half}, MSB first
// - MEM_W 1  width of mem_ctrl {mem_write}
// PORTS
// - clk           in  1   rising-edge clock
// - rst           in  1   asynchronous, active-low reset
// - ex_flush      in  1   squash the instruction entering EX/MEM
// - ex_ctrl       in  10  {cp0_wb,cp0_write,reg_dst,is_slt,save_pc,alu_src,aluop[3:0]}
// - pc_p1         in  30  word PC+1 ([31:2])
// - instr         in  32  instruction word
// - rd1, rd2      in  32  register-file read data (rs, rt)
// - ext_b         in  32  extended immediate
// - mem_ctrl_i    in  MEM_W, wb_ctrl_i in WB_W: control bundles passed down the pipe
// - mem_back      in  38  {we,rw[4:0],data[31:0]} from the MEM stage
// - wb_back       in  38  same layout, from the WB stage
// - cp0_rdata     in  32  CP0 read data (addr = instr[15:11])
// - cp0_wr        out 38  {cp0_write,instr[15:11],f_rd2}
// - br_addr       out 32  bridge byte address
// - br_wdata      out 32  store data
// - br_be         out 4   byte enables
// - br_we         out 1   write strobe
// - br_rdata      in  32  bridge read data (combinational)
// - ex_rw         out 5   destination register, to the stall detector
// - ex_reg_write  out 1   wb_ctrl_i.reg_write
// - ex_mem_to_reg out 1   wb_ctrl_i.mem_to_reg
// - mem_data_o    out 37  registered {ex_rw,ex_out}
// - mem_ctrl_o    out MEM_W, wb_ctrl_o out WB_W: registered control
// - dm_out        out 32  registered br_rdata
// BEHAVIOUR
// - Forwarding (rs=instr[25:21], rt=instr[20:16], per operand):
//   - Use mem_back.data if mem_back.we and rw!=0 and rw==src.
//   - Otherwise use wb_back with the same test; otherwise rd1/rd2.
//   - MEM has priority over WB.
// - ALU operands: A=f_rd1; B = alu_src ? ext_b : f_rd2; sa=instr[10:6].
// - aluop: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL sa, 7 SRL sa, 8 SRA sa,
//   9 SLLV, 10 SRLV, 11 SRAV (shift amount A[4:0], shifts B), 12 LUI {B[15:0],16'h0},
//   13 SLTU (1 if A<B unsigned), 14-15 give 0.
// - All arithmetic wraps mod 2^32 with no overflow trap. Internal zero flag = (C==0).
// - Address: sum = A+B always, independent of aluop; br_addr = sum.
// - ex_out priority:
//   - is_slt: {31'b0,C[31]}
//   - save_pc: {pc_p1,2'b00}
//   - cp0_wb: cp0_rdata
//   - else C
// - ex_rw:
//   - save_pc && !reg_dst: 31
//   - reg_dst: instr[15:11]
//   - else instr[20:16]
// - Stores: br_we = mem_write.
//   - byte: be = 1<<addr[1:0], wdata = {4{f_rd2[7:0]}}
//   - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{f_rd2[15:0]}}
//   - word: be = 4'hF, wdata = f_rd2
//   - Loads and non-memory ops drive the same addr with be computed the same way.
// - Misaligned addresses are not checked; the low bits are ignored.
// - dm_out <= br_rdata every cycle, unaffected by flush.
// - EX/MEM register, on posedge clk:
//   - ex_flush: mem_ctrl_o and wb_ctrl_o <= 0; mem_data_o holds its value.
//   - else: all three registers load.
// - Reset (rst=0, asynchronous): mem_data_o, mem_ctrl_o, wb_ctrl_o, dm_out = 0.
//   Combinational outputs follow their inputs.
// STRUCTURE
// - Package ex_pkg: aluop localparams, ex_ctrl_t/wb_ctrl_t/bypass_t packed structs.
// - Sub-modules: ex_forward (per-operand mux), ex_alu (combinational). Byte-lane logic stays inline.
// TESTING
// - ADD with rd1=5, rd2=7, no forwarding -> after clk, mem_data_o[31:0]=12.
// - rs=3: mem_back={1,3,0xAA}, wb_back={1,3,0xBB}, ADD with rd2=0 -> 0xAA.
//   Drop mem_back.we -> 0xBB. Set rw=0 -> rd1.
// - Store byte: f_rd2=0x12345678, sum=0x1002 -> br_be=4'b0100, br_wdata=0x78787878.
//   Same with half at 0x1002 -> br_be=4'b1100.
// - save_pc, reg_dst=0, pc_p1=0x100 -> ex_rw=31, ex_out=0x400.
//   is_slt with SUB of 1-2 -> ex_out=1.
// - ex_flush=1 with wb_ctrl_i=4'hF -> wb_ctrl_o=0 and mem_data_o unchanged.
//   Assert rst mid-cycle -> all registered outputs 0 immediately.

Source files
------------

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// ex_pkg : shared types and ALU opcodes for the MIPS execute stage
// Revision: 1.0
// ============================================================================
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLLV = 4'd9;
  localparam logic [3:0] ALU_SRLV = 4'd10;
  localparam logic [3:0] ALU_SRAV = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;
  localparam logic [3:0] ALU_SLTU = 4'd13;

  typedef struct packed {
    logic       cp0_wb;
    logic       cp0_write;
    logic       reg_dst;
    logic       is_slt;
    logic       save_pc;
    logic       alu_src;
    logic [3:0] aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic is_dm_byte;
    logic is_dm_half;
  } wb_ctrl_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] data;
  } bypass_t;

endpackage
`default_nettype wire

// File: rtl/ex_alu.sv
`default_nettype none
// ============================================================================
// ex_alu : combinational 32-bit ALU, wrapping arithmetic, no overflow trap
// Revision: 1.0
// ============================================================================
module ex_alu
  import ex_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  input  logic [3:0]  aluop,
  output logic [31:0] c
);

  always_comb begin
    c = 32'd0;
    case (aluop)
      ALU_ADD:  c = a + b;
      ALU_SUB:  c = a - b;
      ALU_AND:  c = a & b;
      ALU_OR:   c = a | b;
      ALU_XOR:  c = a ^ b;
      ALU_NOR:  c = ~(a | b);
      ALU_SLL:  c = b << sa;
      ALU_SRL:  c = b >> sa;
      ALU_SRA:  c = $signed(b) >>> sa;
      ALU_SLLV: c = b << a[4:0];
      ALU_SRLV: c = b >> a[4:0];
      ALU_SRAV: c = $signed(b) >>> a[4:0];
      ALU_LUI:  c = {b[15:0], 16'h0000};
      ALU_SLTU: c = {31'd0, (a < b)};
      default:  c = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_forward.sv
`default_nettype none
// ============================================================================
// ex_forward : per-operand bypass mux, MEM result preferred over WB result
// Revision: 1.0
// ============================================================================
module ex_forward
  import ex_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [31:0] rd_data,
  input  bypass_t     mem_back,
  input  bypass_t     wb_back,
  output logic [31:0] data
);

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hardwired zero, so a write to it must never be bypassed.
  assign mem_hit = mem_back.we && (mem_back.rw != 5'd0) && (mem_back.rw == src);
  assign wb_hit  = wb_back.we  && (wb_back.rw  != 5'd0) && (wb_back.rw  == src);

  always_comb begin
    data = rd_data;
    if (mem_hit)     data = mem_back.data;
    else if (wb_hit) data = wb_back.data;
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage : MIPS execute stage - forwarding, ALU, bridge access, EX/MEM reg
// Revision: 1.0
// ============================================================================
module ex_stage
  import ex_pkg::*;
#(
  parameter int WB_W  = 4,
  parameter int MEM_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_flush,
  input  logic [9:0]       ex_ctrl,
  input  logic [29:0]      pc_p1,
  input  logic [31:0]      instr,
  input  logic [31:0]      rd1,
  input  logic [31:0]      rd2,
  input  logic [31:0]      ext_b,
  input  logic [MEM_W-1:0] mem_ctrl_i,
  input  logic [WB_W-1:0]  wb_ctrl_i,
  input  logic [37:0]      mem_back,
  input  logic [37:0]      wb_back,
  input  logic [31:0]      cp0_rdata,
  output logic [37:0]      cp0_wr,
  output logic [31:0]      br_addr,
  output logic [31:0]      br_wdata,
  output logic [3:0]       br_be,
  output logic             br_we,
  input  logic [31:0]      br_rdata,
  output logic [4:0]       ex_rw,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic [36:0]      mem_data_o,
  output logic [MEM_W-1:0] mem_ctrl_o,
  output logic [WB_W-1:0]  wb_ctrl_o,
  output logic [31:0]      dm_out
);

  ex_ctrl_t    ctrl;
  wb_ctrl_t    wb;
  bypass_t     mem_bp;
  bypass_t     wb_bp;
  logic [4:0]  fwd_src [2];
  logic [31:0] fwd_rd  [2];
  logic [31:0] fwd_out [2];
  logic [31:0] f_rd1;
  logic [31:0] f_rd2;
  logic [31:0] alu_b;
  logic [31:0] alu_c;
  logic [31:0] sum;
  logic [31:0] ex_out;

  logic [36:0]      mem_data_d, mem_data_q;
  logic [MEM_W-1:0] mem_ctrl_d, mem_ctrl_q;
  logic [WB_W-1:0]  wb_ctrl_d,  wb_ctrl_q;
  logic [31:0]      dm_out_d,   dm_out_q;

  assign ctrl   = ex_ctrl_t'(ex_ctrl);
  assign wb     = wb_ctrl_t'(wb_ctrl_i[WB_W-1 -: 4]);
  assign mem_bp = bypass_t'(mem_back);
  assign wb_bp  = bypass_t'(wb_back);

  assign fwd_src[0] = instr[25:21];
  assign fwd_src[1] = instr[20:16];
  assign fwd_rd[0]  = rd1;
  assign fwd_rd[1]  = rd2;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_fwd
      ex_forward u_fwd (
        .src      (fwd_src[g]),
        .rd_data  (fwd_rd[g]),
        .mem_back (mem_bp),
        .wb_back  (wb_bp),
        .data     (fwd_out[g])
      );
    end
  endgenerate

  assign f_rd1 = fwd_out[0];
  assign f_rd2 = fwd_out[1];
  assign alu_b = ctrl.alu_src ? ext_b : f_rd2;

  ex_alu u_alu (
    .a     (f_rd1),
    .b     (alu_b),
    .sa    (instr[10:6]),
    .aluop (ctrl.aluop),
    .c     (alu_c)
  );

  // Address adder runs regardless of aluop so loads/stores need no ADD decode.
  assign sum     = f_rd1 + alu_b;
  assign br_addr = sum;
  assign br_we   = mem_ctrl_i[MEM_W-1];

  always_comb begin
    br_be    = 4'hF;
    br_wdata = f_rd2;
    if (wb.is_dm_byte) begin
      br_be    = 4'b0001 << sum[1:0];
      br_wdata = {4{f_rd2[7:0]}};
    end else if (wb.is_dm_half) begin
      br_be    = sum[1] ? 4'b1100 : 4'b0011;
      br_wdata = {2{f_rd2[15:0]}};
    end
  end

  always_comb begin
    ex_out = alu_c;
    if (ctrl.is_slt)       ex_out = {31'd0, alu_c[31]};
    else if (ctrl.save_pc) ex_out = {pc_p1, 2'b00};
    else if (ctrl.cp0_wb)  ex_out = cp0_rdata;
  end

  always_comb begin
    ex_rw = instr[20:16];
    if (ctrl.save_pc && !ctrl.reg_dst) ex_rw = 5'd31;
    else if (ctrl.reg_dst)             ex_rw = instr[15:11];
  end

  assign ex_reg_write  = wb.reg_write;
  assign ex_mem_to_reg = wb.mem_to_reg;
  assign cp0_wr        = {ctrl.cp0_write, instr[15:11], f_rd2};

  // A flushed slot becomes a bubble by clearing its control; the data is don't-care.
  always_comb begin
    mem_data_d = {ex_rw, ex_out};
    mem_ctrl_d = mem_ctrl_i;
    wb_ctrl_d  = wb_ctrl_i;
    dm_out_d   = br_rdata;
    if (ex_flush) begin
      mem_data_d = mem_data_q;
      mem_ctrl_d = '0;
      wb_ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data_q <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
      dm_out_q   <= '0;
    end else begin
      mem_data_q <= mem_data_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
      dm_out_q   <= dm_out_d;
    end
  end

  assign mem_data_o = mem_data_q;
  assign mem_ctrl_o = mem_ctrl_q;
  assign wb_ctrl_o  = wb_ctrl_q;
  assign dm_out     = dm_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_stage : directed self-checking bench for ex_stage
// Revision: 1.0
// ============================================================================
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        ex_flush;
  logic [9:0]  ex_ctrl;
  logic [29:0] pc_p1;
  logic [31:0] instr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] ext_b;
  logic [0:0]  mem_ctrl_i;
  logic [3:0]  wb_ctrl_i;
  logic [37:0] mem_back;
  logic [37:0] wb_back;
  logic [31:0] cp0_rdata;
  logic [37:0] cp0_wr;
  logic [31:0] br_addr;
  logic [31:0] br_wdata;
  logic [3:0]  br_be;
  logic        br_we;
  logic [31:0] br_rdata;
  logic [4:0]  ex_rw;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [36:0] mem_data_o;
  logic [0:0]  mem_ctrl_o;
  logic [3:0]  wb_ctrl_o;
  logic [31:0] dm_out;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_stage #(.WB_W(4), .MEM_W(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_flush      (ex_flush),
    .ex_ctrl       (ex_ctrl),
    .pc_p1         (pc_p1),
    .instr         (instr),
    .rd1           (rd1),
    .rd2           (rd2),
    .ext_b         (ext_b),
    .mem_ctrl_i    (mem_ctrl_i),
    .wb_ctrl_i     (wb_ctrl_i),
    .mem_back      (mem_back),
    .wb_back       (wb_back),
    .cp0_rdata     (cp0_rdata),
    .cp0_wr        (cp0_wr),
    .br_addr       (br_addr),
    .br_wdata      (br_wdata),
    .br_be         (br_be),
    .br_we         (br_we),
    .br_rdata      (br_rdata),
    .ex_rw         (ex_rw),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .mem_data_o    (mem_data_o),
    .mem_ctrl_o    (mem_ctrl_o),
    .wb_ctrl_o     (wb_ctrl_o),
    .dm_out        (dm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa);
    return {6'd0, rs, rt, rd, sa, 6'd0};
  endfunction

  task automatic idle_inputs();
    ex_flush   = 1'b0;
    ex_ctrl    = 10'h000;
    pc_p1      = 30'd0;
    instr      = 32'd0;
    rd1        = 32'd0;
    rd2        = 32'd0;
    ext_b      = 32'd0;
    mem_ctrl_i = 1'b0;
    wb_ctrl_i  = 4'h0;
    mem_back   = 38'd0;
    wb_back    = 38'd0;
    cp0_rdata  = 32'd0;
    br_rdata   = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    wb_ctrl_i = 4'hF;
    br_rdata  = 32'h1111_2222;
    tick();
    n_cmp++;
    if (mem_data_o !== 37'd0) begin n_fail++; $display("FAIL reset_mem_data got=%h exp=0", mem_data_o); end
    n_cmp++;
    if (wb_ctrl_o !== 4'h0) begin n_fail++; $display("FAIL reset_wb_ctrl got=%h exp=0", wb_ctrl_o); end
    n_cmp++;
    if (dm_out !== 32'd0) begin n_fail++; $display("FAIL reset_dm_out got=%h exp=0", dm_out); end
    rst = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_add();
    idle_inputs();
    ex_ctrl    = 10'h080;
    instr      = mk_instr(5'd1, 5'd2, 5'd3, 5'd0);
    rd1        = 32'd5;
    rd2        = 32'd7;
    wb_ctrl_i  = 4'h8;
    br_rdata   = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (ex_rw !== 5'd3) begin n_fail++; $display("FAIL add_ex_rw got=%0d exp=3", ex_rw); end
    n_cmp++;
    if (ex_reg_write !== 1'b1 || ex_mem_to_reg !== 1'b0) begin
      n_fail++; $display("FAIL add_wb_flags got=%b%b exp=10", ex_reg_write, ex_mem_to_reg);
    end
    tick();
    n_cmp++;
    if (mem_data_o !== {5'd3, 32'd12}) begin n_fail++; $display("FAIL add_result got=%h exp=%h", mem_data_o, {5'd3, 32'd12}); end
    n_cmp++;
    if (wb_ctrl_o !== 4'h8) begin n_fail++; $display("FAIL add_wb_ctrl got=%h exp=8", wb_ctrl_o); end
    n_cmp++;
    if (dm_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL add_dm_out got=%h exp=deadbeef", dm_out); end
  endtask

  task automatic test_forward();
    idle_inputs();
    ex_ctrl  = 10'h000;
    instr    = mk_instr(5'd3, 5'd4, 5'd0, 5'd0);
    rd1      = 32'h11;
    rd2      = 32'd0;
    mem_back = {1'b1, 5'd3, 32'hAA};
    wb_back  = {1'b1, 5'd3, 32'hBB};
    #1;
    n_cmp++;
    if (br_addr !== 32'hAA) begin n_fail++; $display("FAIL fwd_mem got=%h exp=aa", br_addr); end
    mem_back = {1'b0, 5'd3, 32'hAA};
    #1;
    n_cmp++;
    if (br_addr !== 32'hBB) begin n_fail++; $display("FAIL fwd_wb got=%h exp=bb", br_addr); end
    mem_back = {1'b1, 5'd0, 32'hAA};
    wb_back  = {1'b1, 5'd0, 32'hBB};
    #1;
    n_cmp++;
    if (br_addr !== 32'h11) begin n_fail++; $display("FAIL fwd_r0 got=%h exp=11", br_addr); end
    // rt operand forwarded from WB; rs from MEM
    mem_back = {1'b1, 5'd3, 32'h100};
    wb_back  = {1'b1, 5'd4, 32'h23};
    #1;
    n_cmp++;
    if (br_addr !== 32'h123) begin n_fail++; $display("FAIL fwd_both got=%h exp=123", br_addr); end
    tick();
    n_cmp++;
    if (mem_data_o[31:0] !== 32'h123) begin n_fail++; $display("FAIL fwd_reg got=%h exp=123", mem_data_o[31:0]); end
  endtask

  task automatic test_store();
    idle_inputs();
    ex_ctrl    = 10'h010;
    instr      = mk_instr(5'd1, 5'd2, 5'd0, 5'd0);
    rd1        = 32'h1000;
    ext_b      = 32'd2;
    rd2        = 32'h1234_5678;
    mem_ctrl_i = 1'b1;
    wb_ctrl_i  = 4'b0010;
    #1;
    n_cmp++;
    if (br_addr !== 32'h1002) begin n_fail++; $display("FAIL st_addr got=%h exp=1002", br_addr); end
    n_cmp++;
    if (br_be !== 4'b0100 || br_wdata !== 32'h7878_7878) begin
      n_fail++; $display("FAIL st_byte got=%b/%h exp=0100/78787878", br_be, br_wdata);
    end
    n_cmp++;
    if (br_we !== 1'b1) begin n_fail++; $display("FAIL st_we got=%b exp=1", br_we); end
    ext_b = 32'd3;
    #1;
    n_cmp++;
    if (br_be !== 4'b1000) begin n_fail++; $display("FAIL st_byte3 got=%b exp=1000", br_be); end
    ext_b     = 32'd2;
    wb_ctrl_i = 4'b0001;
    #1;
    n_cmp++;
    if (br_be !== 4'b1100 || br_wdata !== 32'h5678_5678) begin
      n_fail++; $display("FAIL st_half got=%b/%h exp=1100/56785678", br_be, br_wdata);
    end
    ext_b = 32'd0;
    #1;
    n_cmp++;
    if (br_be !== 4'b0011) begin n_fail++; $display("FAIL st_half_lo got=%b exp=0011", br_be); end
    wb_ctrl_i = 4'b0000;
    #1;
    n_cmp++;
    if (br_be !== 4'hF || br_wdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL st_word got=%b/%h exp=1111/12345678", br_be, br_wdata);
    end
    mem_ctrl_i = 1'b0;
    #1;
    n_cmp++;
    if (br_we !== 1'b0) begin n_fail++; $display("FAIL ld_we got=%b exp=0", br_we); end
    tick();
  endtask

  task automatic test_alu_ops();
    logic [3:0]  op  [9] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd13, 4'd14};
    logic [31:0] a   [9] = '{32'd5, 32'hF0F0, 32'd0, 32'd0, 32'd0, 32'd8, 32'd0, 32'd1, 32'd9};
    logic [31:0] b   [9] = '{32'd7, 32'hFF00, 32'hFFFF_0000, 32'd1, 32'h8000_0000,
                             32'h8000_0000, 32'h1234, 32'hFFFF_FFFF, 32'd9};
    logic [4:0]  sa  [9] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] exp [9] = '{32'hFFFF_FFFE, 32'hF000, 32'h0000_FFFF, 32'h10, 32'hF800_0000,
                             32'h0080_0000, 32'h1234_0000, 32'd1, 32'd0};
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      ex_ctrl = {6'b000001, op[i]};
      instr   = mk_instr(5'd1, 5'd2, 5'd0, sa[i]);
      rd1     = a[i];
      ext_b   = b[i];
      tick();
      n_cmp++;
      if (mem_data_o !== {5'd2, exp[i]}) begin
        n_fail++; $display("FAIL alu_op%0d got=%h exp=%h", op[i], mem_data_o, {5'd2, exp[i]});
      end
    end
  endtask

  task automatic test_result_select();
    idle_inputs();
    ex_ctrl = 10'h020;
    instr   = mk_instr(5'd1, 5'd2, 5'd7, 5'd0);
    pc_p1   = 30'h100;
    #1;
    n_cmp++;
    if (ex_rw !== 5'd31) begin n_fail++; $display("FAIL savepc_rw got=%0d exp=31", ex_rw); end
    tick();
    n_cmp++;
    if (mem_data_o !== {5'd31, 32'h400}) begin n_fail++; $display("FAIL savepc_out got=%h exp=%h", mem_data_o, {5'd31, 32'h400}); end
    idle_inputs();
    ex_ctrl = 10'h041;
    instr   = mk_instr(5'd1, 5'd2, 5'd7, 5'd0);
    rd1     = 32'd1;
    rd2     = 32'd2;
    tick();
    n_cmp++;
    if (mem_data_o !== {5'd2, 32'd1}) begin n_fail++; $display("FAIL slt_out got=%h exp=%h", mem_data_o, {5'd2, 32'd1}); end
    idle_inputs();
    ex_ctrl   = 10'h300;
    instr     = mk_instr(5'd1, 5'd2, 5'd5, 5'd0);
    rd2       = 32'h55;
    cp0_rdata = 32'hCAFE;
    #1;
    n_cmp++;
    if (cp0_wr !== {1'b1, 5'd5, 32'h55}) begin n_fail++; $display("FAIL cp0_wr got=%h exp=%h", cp0_wr, {1'b1, 5'd5, 32'h55}); end
    tick();
    n_cmp++;
    if (mem_data_o !== {5'd2, 32'hCAFE}) begin n_fail++; $display("FAIL cp0_wb got=%h exp=%h", mem_data_o, {5'd2, 32'hCAFE}); end
  endtask

  task automatic test_flush();
    idle_inputs();
    ex_ctrl    = 10'h080;
    instr      = mk_instr(5'd1, 5'd2, 5'd9, 5'd0);
    rd1        = 32'd5;
    rd2        = 32'd7;
    mem_ctrl_i = 1'b1;
    wb_ctrl_i  = 4'h8;
    tick();
    n_cmp++;
    if (mem_ctrl_o !== 1'b1) begin n_fail++; $display("FAIL pre_flush_mem_ctrl got=%b exp=1", mem_ctrl_o); end
    ex_flush  = 1'b1;
    wb_ctrl_i = 4'hF;
    rd1       = 32'd100;
    instr     = mk_instr(5'd1, 5'd2, 5'd4, 5'd0);
    br_rdata  = 32'h0BAD_F00D;
    tick();
    n_cmp++;
    if (wb_ctrl_o !== 4'h0 || mem_ctrl_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_ctrl got=%h/%b exp=0/0", wb_ctrl_o, mem_ctrl_o);
    end
    n_cmp++;
    if (mem_data_o !== {5'd9, 32'd12}) begin n_fail++; $display("FAIL flush_hold got=%h exp=%h", mem_data_o, {5'd9, 32'd12}); end
    n_cmp++;
    if (dm_out !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL flush_dm_out got=%h exp=0badf00d", dm_out); end
    ex_flush = 1'b0;
  endtask

  task automatic test_async_reset();
    idle_inputs();
    ex_ctrl    = 10'h080;
    instr      = mk_instr(5'd1, 5'd2, 5'd3, 5'd0);
    rd1        = 32'd1;
    rd2        = 32'd1;
    mem_ctrl_i = 1'b1;
    wb_ctrl_i  = 4'hC;
    br_rdata   = 32'h5555_AAAA;
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_data_o !== 37'd0 || mem_ctrl_o !== 1'b0 || wb_ctrl_o !== 4'h0 || dm_out !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h/%b/%h/%h exp=all zero", mem_data_o, mem_ctrl_o, wb_ctrl_o, dm_out);
    end
    n_cmp++;
    if (br_addr !== 32'd2) begin n_fail++; $display("FAIL reset_comb got=%h exp=2", br_addr); end
    #1;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_store();
    test_alu_ops();
    test_result_select();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
